keystone_frame_ctrl: RTL
========================

Name: keystone_frame_ctrl

Overview:
Frame-level controller for the Keystone warp datapath. Holds pending and active copies of the 8 homography coefficients (H11..H32). Commits coefficient and enable changes only at an accepted start-of-frame, so a frame never mixes two matrices. Also sequences software reset: gates input, drains in-flight pixels, pulses a datapath flush, and flags line-length errors on the AXI4-Stream video input.

Parameters:
DATA_W, 32, coefficient width (Q8.24)
FRAME_W, 1920, expected pixels per line
FRAME_H, 1080, expected lines per frame
OUTST_W, 12, width of in-flight pixel counter
DRAIN_TIMEOUT, 4096, max DRAIN cycles before forced flush
FLUSH_CYCLES, 16, dp_flush pulse length

Ports:
aclk  in  1  clock, all logic rising-edge
areset  in  1  synchronous, active-high reset
sw_reset_req  in  1  level from SW_RESET register; rising edge starts reset sequence
enable_req  in  1  ENABLE_KEYSTONE register value
coef_commit  in  1  one-cycle pulse: sample h_in into pending
h_in  in  8*DATA_W  {H32,H31,H23,H22,H21,H13,H12,H11}, H11 in LSBs
in_valid  in  1  s_axis_video_tvalid_in
in_ready_dp  in  1  datapath tready before gating
in_user  in  1  s_axis_video_tuser_in (SOF)
in_last  in  1  s_axis_video_tlast_in (EOL)
out_fire  in  1  output tvalid & tready
in_gate  out  1  AND-ed into tready_out; 0 blocks input
h_active  out  8*DATA_W  coefficients driven to datapath
keystone_en  out  1  1 = warp, 0 = bypass
dp_flush  out  1  datapath pipeline clear
commit_pending  out  1  pending set not yet applied
busy  out  1  state != IDLE
frame_count  out  16  accepted SOFs, wraps
err_line  out  1  sticky: line length != FRAME_W
err_frame  out  1  sticky: line count != FRAME_H at SOF
err_timeout  out  1  sticky: DRAIN timed out

Behaviour:
- accept = in_valid & in_ready_dp & in_gate. sof = accept & in_user. eol = accept & in_last.
- Reset (areset=1, checked at rising edge):
  - h_active = identity: H11 = H22 = 32'h0100_0000, all others 0. Pending is also identity.
  - commit_pending = 0, keystone_en = 0, dp_flush = 0, in_gate = 1, frame_count = 0, all err = 0, counters = 0.
  - State = IDLE.
- States:
  - IDLE -> WAIT_SOF on enable_req=1 or commit_pending=1.
  - WAIT_SOF -> RUN on sof.
  - RUN: stays in RUN across frames.
  - Any state except FLUSH -> DRAIN on sw_reset_req rising edge.
  - DRAIN -> FLUSH when outstanding==0 or the drain timer reaches DRAIN_TIMEOUT; timeout also sets err_timeout.
  - FLUSH -> IDLE after exactly FLUSH_CYCLES cycles.
- Commit:
  - coef_commit copies h_in into pending and sets commit_pending the next cycle.
  - On a sof cycle: h_active <= pending, keystone_en <= enable_req, commit_pending <= 0, registered. The pixel carrying SOF is the first pixel using the new values.
  - coef_commit and sof in the same cycle: h_in goes straight to h_active and commit_pending stays 0 (the newest value wins).
  - No other path changes h_active or keystone_en.
- Counters:
  - outstanding (OUTST_W bits) +1 on accept, -1 on out_fire; both in one cycle = unchanged. Saturates at 0 and at all-ones, never wraps.
  - pix_cnt +1 on accept. On eol: compare pix_cnt+1 with FRAME_W; mismatch sets err_line; pix_cnt clears.
  - line_cnt +1 on eol. On sof: if frame_count != 0 and line_cnt != FRAME_H, set err_frame; then clear line_cnt and pix_cnt, and frame_count +1 (16-bit wrap).
- DRAIN: in_gate = 0; pending cleared to identity; commit_pending = 0; drain timer counts from 0.
- FLUSH: dp_flush = 1; in_gate = 0; outstanding, pix_cnt and line_cnt forced to 0; h_active and keystone_en held.
- sw_reset_req held high keeps the block in IDLE after FLUSH; edge detection prevents re-entry.
- Error flags clear only on areset or entry to FLUSH.
- areset mid-DRAIN or mid-FLUSH: immediate reset values; no completion pulse.

Test Plan:
- Reset, enable_req=1, SOF pixel accepted at cycle 10 -> keystone_en=1 from cycle 11; h_active identity; frame_count=1.
- coef_commit with H13=32'h0000_1000 mid-frame -> commit_pending=1, h_active unchanged until next SOF; after SOF, H13=0x1000 and commit_pending=0.
- coef_commit on the SOF cycle with H11=32'h0080_0000 -> h_active H11=0x0080_0000 next cycle; commit_pending stays 0.
- 5 pixels accepted, datapath stalled (out_fire=0), sw_reset_req rises -> in_gate=0; DRAIN holds until 5 out_fire; then dp_flush high exactly 16 cycles; IDLE; err_timeout=0.
- Same with out_fire stuck low, DRAIN_TIMEOUT=32 -> FLUSH entered 32 cycles after DRAIN entry; err_timeout=1.
- Line with tlast on pixel 1919 (FRAME_W=1920) -> err_line=1; next line of 1920 pixels leaves err_line=1; simultaneous accept and out_fire leave outstanding unchanged.

Source files
------------

// File: rtl/keystone_frame_ctrl.sv
// Frame controller for the Keystone warp datapath. Coefficients and enable commit only at SOF; software reset drains, flushes, then idles.
// Latency: all outputs registered, one cycle after the causing input. Backpressure: in_gate drops for all of DRAIN and FLUSH.
module keystone_frame_ctrl #(
    parameter int DATA_W        = 32,
    parameter int FRAME_W       = 1920,
    parameter int FRAME_H       = 1080,
    parameter int OUTST_W       = 12,
    parameter int DRAIN_TIMEOUT = 4096,
    parameter int FLUSH_CYCLES  = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  sw_reset_req,
    input  logic                  enable_req,
    input  logic                  coef_commit,
    input  logic [8*DATA_W-1:0]   h_in,
    input  logic                  in_valid,
    input  logic                  in_ready_dp,
    input  logic                  in_user,
    input  logic                  in_last,
    input  logic                  out_fire,
    output logic                  in_gate,
    output logic [8*DATA_W-1:0]   h_active,
    output logic                  keystone_en,
    output logic                  dp_flush,
    output logic                  commit_pending,
    output logic                  busy,
    output logic [15:0]           frame_count,
    output logic                  err_line,
    output logic                  err_frame,
    output logic                  err_timeout
);

    localparam int DT_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam int FL_W = $clog2(FLUSH_CYCLES + 1);

    // Q8.24 unity on H11 and H22, zero elsewhere
    localparam logic [DATA_W-1:0]   ONE_Q   = {8'h01, {(DATA_W-8){1'b0}}};
    localparam logic [8*DATA_W-1:0] H_IDENT = {{(3*DATA_W){1'b0}}, ONE_Q, {(3*DATA_W){1'b0}}, ONE_Q};

    typedef enum logic [2:0] {IDLE, WAIT_SOF, RUN, DRAIN, FLUSH} state_t;

    state_t                 state_q;
    logic                   sw_q;
    logic                   in_gate_q;
    logic                   dp_flush_q;
    logic                   keystone_en_q;
    logic                   commit_pending_q;
    logic                   err_line_q;
    logic                   err_frame_q;
    logic                   err_timeout_q;
    logic [8*DATA_W-1:0]    h_active_q;
    logic [8*DATA_W-1:0]    h_pend_q;
    logic [15:0]            frame_count_q;
    logic [DT_W-1:0]        drain_t_q;
    logic [FL_W-1:0]        flush_t_q;
    logic [OUTST_W-1:0]     outst_q, outst_d;
    logic [15:0]            pix_q, pix_d;
    logic [15:0]            line_q, line_d;

    logic        accept, sof, eol, sw_rise;
    logic [15:0] pix_base;
    logic        line_err, frame_err;
    logic        drain_done, drain_to;

    assign accept    = in_valid & in_ready_dp & in_gate_q;
    assign sof       = accept & in_user;
    assign eol       = accept & in_last;
    assign sw_rise   = sw_reset_req & ~sw_q;

    // The SOF pixel starts a fresh line, so it counts from zero.
    assign pix_base  = sof ? 16'd0 : pix_q;
    assign line_err  = eol && (({1'b0, pix_base} + 17'd1) != 17'(FRAME_W));
    assign frame_err = sof && (frame_count_q != 16'd0) && (line_q != 16'(FRAME_H));

    assign drain_done = (outst_q == '0);
    assign drain_to   = (drain_t_q == DT_W'(DRAIN_TIMEOUT - 1));

    always_comb begin
        outst_d = outst_q;
        if (accept && !out_fire && (outst_q != '1)) begin
            outst_d = outst_q + 1'b1;
        end else if (out_fire && !accept && (outst_q != '0)) begin
            outst_d = outst_q - 1'b1;
        end

        pix_d = pix_q;
        if (eol) begin
            pix_d = 16'd0;
        end else if (accept) begin
            pix_d = pix_base + 16'd1;
        end

        line_d = line_q;
        if (sof) begin
            line_d = eol ? 16'd1 : 16'd0;
        end else if (eol) begin
            line_d = line_q + 16'd1;
        end

        if (state_q == FLUSH) begin
            outst_d = '0;
            pix_d   = 16'd0;
            line_d  = 16'd0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            outst_q <= '0;
            pix_q   <= 16'd0;
            line_q  <= 16'd0;
        end else begin
            outst_q <= outst_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
        end
    end

    always_ff @(posedge aclk) begin
        sw_q <= sw_reset_req;
        if (areset) begin
            state_q          <= IDLE;
            in_gate_q        <= 1'b1;
            dp_flush_q       <= 1'b0;
            keystone_en_q    <= 1'b0;
            commit_pending_q <= 1'b0;
            err_line_q       <= 1'b0;
            err_frame_q      <= 1'b0;
            err_timeout_q    <= 1'b0;
            h_active_q       <= H_IDENT;
            h_pend_q         <= H_IDENT;
            frame_count_q    <= 16'd0;
            drain_t_q        <= '0;
            flush_t_q        <= '0;
        end else begin
            // A commit landing on the SOF cycle bypasses pending so the newest set wins.
            if (sof) begin
                h_active_q       <= coef_commit ? h_in : h_pend_q;
                keystone_en_q    <= enable_req;
                commit_pending_q <= 1'b0;
                frame_count_q    <= frame_count_q + 16'd1;
                if (coef_commit) begin
                    h_pend_q <= h_in;
                end
            end else if (coef_commit) begin
                h_pend_q         <= h_in;
                commit_pending_q <= 1'b1;
            end

            if (line_err) begin
                err_line_q <= 1'b1;
            end
            if (frame_err) begin
                err_frame_q <= 1'b1;
            end

            if (sw_rise && (state_q != FLUSH) && (state_q != DRAIN)) begin
                state_q   <= DRAIN;
                in_gate_q <= 1'b0;
                drain_t_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (enable_req || commit_pending_q) begin
                            state_q <= WAIT_SOF;
                        end
                    end
                    WAIT_SOF: begin
                        if (sof) begin
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        state_q <= RUN;
                    end
                    DRAIN: begin
                        h_pend_q         <= H_IDENT;
                        commit_pending_q <= 1'b0;
                        if (drain_done || drain_to) begin
                            state_q       <= FLUSH;
                            dp_flush_q    <= 1'b1;
                            flush_t_q     <= '0;
                            err_line_q    <= 1'b0;
                            err_frame_q   <= 1'b0;
                            err_timeout_q <= ~drain_done;
                        end else begin
                            drain_t_q <= drain_t_q + 1'b1;
                        end
                    end
                    FLUSH: begin
                        if (flush_t_q == FL_W'(FLUSH_CYCLES - 1)) begin
                            state_q    <= IDLE;
                            dp_flush_q <= 1'b0;
                            in_gate_q  <= 1'b1;
                        end else begin
                            flush_t_q <= flush_t_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign in_gate        = in_gate_q;
    assign h_active       = h_active_q;
    assign keystone_en    = keystone_en_q;
    assign dp_flush       = dp_flush_q;
    assign commit_pending = commit_pending_q;
    assign busy           = (state_q != IDLE);
    assign frame_count    = frame_count_q;
    assign err_line       = err_line_q;
    assign err_frame      = err_frame_q;
    assign err_timeout    = err_timeout_q;

endmodule
